// File: rtl/ws2811_pkg.sv
// ============================================================================
//  ws2811_pkg
//  Shared state encoding, 50 MHz timing defaults and GRB packing for WS2811.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ws2811_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SEND  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int DEF_NUM_LEDS     = 64;
    localparam int DEF_FETCH_CYCLES = 32;
    localparam int DEF_T0H          = 20;
    localparam int DEF_T1H          = 40;
    localparam int DEF_TBIT         = 63;
    localparam int DEF_TRESET       = 3000;

    localparam int BITS_PER_PIXEL   = 24;

    // Wire order on the string is green, red, blue, each MSB first.
    function automatic logic [BITS_PER_PIXEL-1:0] pack_grb(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {g, r, b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws2811_bit_encoder.sv
// ============================================================================
//  ws2811_bit_encoder
//  NRZ pulse-width encoder: one TBIT-long bit cell per bit while go is high.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ws2811_bit_encoder
    import ws2811_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic bit_i,
    input  logic go_i,
    output logic dout_o,
    output logic bit_end_o
);

    localparam int CW = $clog2(TBIT);
    localparam logic [CW-1:0] C_T0H  = CW'(T0H);
    localparam logic [CW-1:0] C_T1H  = CW'(T1H);
    localparam logic [CW-1:0] C_LAST = CW'(TBIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] w_high;

    assign w_high    = bit_i ? C_T1H : C_T0H;
    assign bit_end_o = go_i && (cnt_q == C_LAST);
    assign dout_o    = go_i && (cnt_q < w_high);

    // Timer parks at zero whenever go drops so the next cell starts cleanly.
    always_comb begin
        cnt_d = cnt_q;
        if (!go_i || bit_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ws2811_transmitter.sv
// ============================================================================
//  ws2811_transmitter
//  Frame sequencer: pixel fetch, shadow prefetch, GRB serialisation, reset gap.
//  Option macro WS2811_AUTO_REFRESH_EN: GAP restarts the next frame directly.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ws2811_transmitter
    import ws2811_pkg::*;
#(
    parameter int NUM_LEDS     = DEF_NUM_LEDS,
    parameter int FETCH_CYCLES = DEF_FETCH_CYCLES,
    parameter int T0H          = DEF_T0H,
    parameter int T1H          = DEF_T1H,
    parameter int TBIT         = DEF_TBIT,
    parameter int TRESET       = DEF_TRESET
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [7:0] ledindex,
    output logic       dout,
    output logic       busy,
    output logic       frame_done
);

    localparam int FW = $clog2(FETCH_CYCLES + 1);
    localparam int GW = $clog2(TRESET + 1);
    localparam logic [FW-1:0] C_FETCH_LAST = FW'(FETCH_CYCLES - 1);
    localparam logic [GW-1:0] C_GAP_END    = GW'(TRESET);
    localparam logic [7:0]    C_LAST_PIX   = 8'(NUM_LEDS - 1);
    localparam logic [4:0]    C_TOP_BIT    = 5'(BITS_PER_PIXEL - 1);

    state_t                      state_q,      state_d;
    logic [7:0]                  ledindex_q,   ledindex_d;
    logic [7:0]                  px_q,         px_d;
    logic [FW-1:0]               fetch_cnt_q,  fetch_cnt_d;
    logic                        fetch_act_q,  fetch_act_d;
    logic [BITS_PER_PIXEL-1:0]   shadow_q,     shadow_d;
    logic                        shadow_vld_q, shadow_vld_d;
    logic [BITS_PER_PIXEL-1:0]   shift_q,      shift_d;
    logic [4:0]                  bitcnt_q,     bitcnt_d;
    logic                        wait_q,       wait_d;
    logic [GW-1:0]               gap_cnt_q,    gap_cnt_d;

    logic w_go;
    logic w_bit_end;
    logic w_fetch_done;
    logic w_last;
    logic w_more;
    logic w_pixel_end;

    assign w_go         = (state_q == ST_SEND) && !wait_q;
    assign w_fetch_done = fetch_act_q && (fetch_cnt_q == C_FETCH_LAST);
    assign w_last       = (px_q == C_LAST_PIX);
    assign w_more       = (ledindex_q < C_LAST_PIX);
    assign w_pixel_end  = w_bit_end && (bitcnt_q == 5'd0);

    assign ledindex   = ledindex_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_GAP) && (gap_cnt_q == C_GAP_END);

    ws2811_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_enc (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_i     (shift_q[BITS_PER_PIXEL-1]),
        .go_i      (w_go),
        .dout_o    (dout),
        .bit_end_o (w_bit_end)
    );

    always_comb begin
        state_d      = state_q;
        ledindex_d   = ledindex_q;
        px_d         = px_q;
        fetch_cnt_d  = fetch_cnt_q;
        fetch_act_d  = fetch_act_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        wait_d       = wait_q;
        gap_cnt_d    = gap_cnt_q;

        // Fetch runs independently of the serialiser; PRIME overrides its capture.
        if (fetch_act_q) begin
            if (w_fetch_done) begin
                shadow_d     = pack_grb(red, green, blue);
                shadow_vld_d = 1'b1;
                fetch_act_d  = 1'b0;
            end else begin
                fetch_cnt_d = fetch_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_PRIME;
                    ledindex_d   = 8'd0;
                    fetch_cnt_d  = '0;
                    fetch_act_d  = 1'b1;
                    shadow_vld_d = 1'b0;
                end
            end
            ST_PRIME: begin
                if (w_fetch_done) begin
                    shift_d      = pack_grb(red, green, blue);
                    bitcnt_d     = C_TOP_BIT;
                    px_d         = 8'd0;
                    shadow_vld_d = 1'b0;
                    state_d      = ST_SEND;
                    if (w_more) begin
                        ledindex_d  = ledindex_q + 8'd1;
                        fetch_cnt_d = '0;
                        fetch_act_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (wait_q || w_pixel_end) begin
                    if (w_last && !wait_q) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else if (shadow_vld_q) begin
                        shift_d      = shadow_q;
                        bitcnt_d     = C_TOP_BIT;
                        px_d         = px_q + 8'd1;
                        shadow_vld_d = 1'b0;
                        wait_d       = 1'b0;
                        if (w_more) begin
                            ledindex_d  = ledindex_q + 8'd1;
                            fetch_cnt_d = '0;
                            fetch_act_d = 1'b1;
                        end
                    end else begin
                        // Prefetch late: hold the line low until the shadow fills.
                        wait_d = 1'b1;
                    end
                end else if (w_bit_end) begin
                    shift_d  = {shift_q[BITS_PER_PIXEL-2:0], 1'b0};
                    bitcnt_d = bitcnt_q - 5'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == C_GAP_END) begin
`ifdef WS2811_AUTO_REFRESH_EN
                    state_d      = ST_PRIME;
                    ledindex_d   = 8'd0;
                    fetch_cnt_d  = '0;
                    fetch_act_d  = 1'b1;
                    shadow_vld_d = 1'b0;
`else
                    state_d      = ST_IDLE;
`endif
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ledindex_q   <= 8'd0;
            px_q         <= 8'd0;
            fetch_cnt_q  <= '0;
            fetch_act_q  <= 1'b0;
            shadow_q     <= '0;
            shadow_vld_q <= 1'b0;
            shift_q      <= '0;
            bitcnt_q     <= 5'd0;
            wait_q       <= 1'b0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ledindex_q   <= ledindex_d;
            px_q         <= px_d;
            fetch_cnt_q  <= fetch_cnt_d;
            fetch_act_q  <= fetch_act_d;
            shadow_q     <= shadow_d;
            shadow_vld_q <= shadow_vld_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            wait_q       <= wait_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    a_no_stall: assert property (@(posedge clk) disable iff (!reset_n)
        !((state_q == ST_SEND) && !wait_q && w_pixel_end && !w_last && !shadow_vld_q));

endmodule

`default_nettype wire

// File: tb/tb_ws2811_transmitter.sv
// ============================================================================
//  tb_ws2811_transmitter
//  Directed/random frames decoded from dout and compared to a GRB bit model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ws2811_transmitter;

    localparam int FA     = 32;
    localparam int NA     = 3;
    localparam int T0H    = 20;
    localparam int T1H    = 40;
    localparam int TBIT   = 63;
    localparam int TRESET = 3000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       startA, startB;
    logic [7:0] rA, gA, bA, rB, gB, bB;
    logic [7:0] ledA, ledB;
    logic       doutA, doutB, busyA, busyB, fdA, fdB;

    logic       sel;
    logic       m_dout, m_busy, m_fd;
    logic [7:0] m_led;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          framesA  = 0;
    int          modeA;
    logic [23:0] const_grb;
    logic [23:0] rnd_tab [0:255];
    logic [23:0] expw    [0:7];
    logic [23:0] pipeA   [0:FA-2];
    bit          idx_bad;

    always #5 clk = ~clk;

    ws2811_transmitter #(
        .NUM_LEDS(NA), .FETCH_CYCLES(FA), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dutA (
        .clk(clk), .reset_n(reset_n), .start(startA), .red(rA), .green(gA), .blue(bA),
        .ledindex(ledA), .dout(doutA), .busy(busyA), .frame_done(fdA)
    );

    ws2811_transmitter #(
        .NUM_LEDS(1), .FETCH_CYCLES(1), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dutB (
        .clk(clk), .reset_n(reset_n), .start(startB), .red(rB), .green(gB), .blue(bB),
        .ledindex(ledB), .dout(doutB), .busy(busyB), .frame_done(fdB)
    );

    assign m_dout = sel ? doutB : doutA;
    assign m_busy = sel ? busyB : busyA;
    assign m_fd   = sel ? fdB   : fdA;
    assign m_led  = sel ? ledB  : ledA;

    // Colour calculator model, returned as the GRB word expected on the wire.
    function automatic logic [23:0] colour(input int m, input logic [7:0] idx);
        case (m)
            0:       return const_grb;
            1:       return {idx, ~idx, 8'h5A};
            default: return rnd_tab[idx];
        endcase
    endfunction

    // Data becomes valid exactly FA clocks after ledindex changes.
    always @(posedge clk) begin
        pipeA[0] <= colour(modeA, ledA);
        for (int j = 1; j <= FA - 2; j++) pipeA[j] <= pipeA[j-1];
    end
    assign {gA, rA, bA} = pipeA[FA-2];

    always @(posedge clk) if (fdA) framesA <= framesA + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sel && ledB !== 8'd0) idx_bad = 1'b1;
    endtask

    task automatic drv_start(input logic s, input logic v);
        if (s) startB = v; else startA = v;
    endtask

    task automatic run_frame(input logic s, input int nled, input int fetch,
                             input bit do_start, input bit cont,
                             input int poke_bit, input bit start_on_done);
        int          k, h, l;
        bit          last, ebit, idle_bad;
        logic [23:0] word;
        if (do_start) begin
            @(negedge clk); drv_start(s, 1'b1);
            @(negedge clk); drv_start(s, 1'b0);
        end
        k = 0;
        do begin tick(); k++; end while (!m_dout && k < fetch + 100);
        check("first_rise", k, do_start ? fetch : fetch + 1);
        for (int p = 0; p < nled; p++) begin
            word = '0;
            for (int b = 23; b >= 0; b--) begin
                ebit = expw[p][b];
                last = (p == nled - 1) && (b == 0);
                h = 0;
                while (m_dout && h < TBIT + 5) begin h++; tick(); end
                l = 0;
                if (!last) begin
                    while (!m_dout && l < TBIT + 5) begin
                        l++;
                        drv_start(s, (p * 24 + 23 - b == poke_bit) && l == 1);
                        tick();
                    end
                    drv_start(s, 1'b0);
                end else begin
                    while (!m_fd && l < TBIT + TRESET + 5) begin l++; tick(); end
                end
                word = {word[22:0], h > (T0H + T1H) / 2};
                check("bit_high", h, ebit ? T1H : T0H);
                check(last ? "last_low_plus_gap" : "bit_low", l,
                      last ? TBIT - h + TRESET : TBIT - h);
            end
            check("pixel_word", word, expw[p]);
        end
        check("frame_done_pulse", m_fd, 1);
        check("ledindex_end", m_led, nled - 1);
        if (cont) begin
            check("busy_in_gap", m_busy, 1);
        end else begin
            if (start_on_done) drv_start(s, 1'b1);
            tick();
            drv_start(s, 1'b0);
            check("frame_done_one_clk", m_fd, 0);
            check("busy_after_frame", m_busy, 0);
            check("dout_after_frame", m_dout, 0);
            idle_bad = 1'b0;
            repeat (100) begin tick(); if (m_busy || m_dout) idle_bad = 1'b1; end
            check("stays_idle", idle_bad, 0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        reset_n = 1'b0; startA = 1'b0; startB = 1'b0; sel = 1'b0; idx_bad = 1'b0;
        modeA = 0; const_grb = 24'hFF0000; {gB, rB, bB} = 24'h0;
        for (int i = 0; i < 256; i++) rnd_tab[i] = 24'($urandom);
        repeat (5) @(posedge clk);
        #1;
        check("rst_dout", doutA, 0);
        check("rst_busy", busyA, 0);
        check("rst_frame_done", fdA, 0);
        check("rst_ledindex", ledA, 0);
        check("rst_dout_b", doutB, 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (40) tick();

`ifdef WS2811_AUTO_REFRESH_EN
        modeA = 1;
        for (int p = 0; p < NA; p++) expw[p] = colour(1, 8'(p));
        f0 = framesA;
        run_frame(1'b0, NA, FA, 1'b1, 1'b1, -1, 1'b0);
        run_frame(1'b0, NA, FA, 1'b0, 1'b1, -1, 1'b0);
        run_frame(1'b0, NA, FA, 1'b0, 1'b1, -1, 1'b0);
        tick();
        check("auto_busy_held", busyA, 1);
        check("auto_frame_count", framesA - f0, 3);
`else
        // Constant colour: green=FF gives eight long then sixteen short pulses.
        for (int p = 0; p < NA; p++) expw[p] = const_grb;
        run_frame(1'b0, NA, FA, 1'b1, 1'b0, -1, 1'b0);

        // Index-dependent colour, with start pokes mid-frame and on frame_done.
        modeA = 1;
        for (int p = 0; p < NA; p++) expw[p] = colour(1, 8'(p));
        f0 = framesA;
        run_frame(1'b0, NA, FA, 1'b1, 1'b0, 30, 1'b1);
        check("frame_count", framesA - f0, 1);

        modeA = 2;
        repeat (2) begin
            for (int i = 0; i < NA; i++) rnd_tab[i] = 24'($urandom);
            for (int p = 0; p < NA; p++) expw[p] = rnd_tab[p];
            run_frame(1'b0, NA, FA, 1'b1, 1'b0, -1, 1'b0);
        end

        // Asynchronous reset during pixel 1, bit 10.
        @(negedge clk); startA = 1'b1;
        @(negedge clk); startA = 1'b0;
        repeat (FA + 34 * TBIT) tick();
        check("pre_reset_dout", doutA, 1);
        check("pre_reset_ledindex", ledA, 2);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_dout", doutA, 0);
        check("async_rst_busy", busyA, 0);
        check("async_rst_ledindex", ledA, 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (5) tick();
        for (int i = 0; i < NA; i++) rnd_tab[i] = 24'($urandom);
        for (int p = 0; p < NA; p++) expw[p] = rnd_tab[p];
        run_frame(1'b0, NA, FA, 1'b1, 1'b0, -1, 1'b0);

        // Single pixel, single-cycle fetch.
        sel = 1'b1;
        {gB, rB, bB} = 24'($urandom);
        expw[0] = {gB, rB, bB};
        idx_bad = 1'b0;
        run_frame(1'b1, 1, 1, 1'b1, 1'b0, -1, 1'b0);
        check("single_ledindex_zero", idx_bad, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
